srt_radix2_iter: RTL and testbench

//  Iterative radix-2 SRT mantissa divider core, digit set {-1,0,+1}.

---
 rtl/srt_div_pkg.sv | 13 +
 rtl/srt_qds.sv | 19 +
 rtl/srt_radix2_iter.sv | 153 +++++++++++++++
 tb/tb_srt_radix2_iter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/srt_div_pkg.sv
// Shared sizes and types for the iterative radix-2 SRT mantissa divider.
package srt_div_pkg;

    localparam int ITER   = 26;
    localparam int MANT_W = 24;
    localparam int REM_W  = 26;
    localparam int CNT_W  = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE} srt_state_t;

    typedef enum logic [1:0] {Q_NEG, Q_ZERO, Q_POS} srt_digit_t;

endpackage

// File: rtl/srt_qds.sv
// Radix-2 SRT quotient digit selection from the 4-bit integer estimate of 2r.
module srt_qds
    import srt_div_pkg::*;
(
    input  logic [3:0] i_estimate,
    output srt_digit_t o_digit
);

    // Estimate is floor(2r) in two's complement: >=1 picks +1, <=-2 picks -1.
    always_comb begin
        o_digit = Q_ZERO;
        if (!i_estimate[3] && (i_estimate != 4'b0000)) begin
            o_digit = Q_POS;
        end else if (i_estimate[3] && (i_estimate != 4'b1111)) begin
            o_digit = Q_NEG;
        end
    end

endmodule

// File: rtl/srt_radix2_iter.sv
// Iterative radix-2 SRT mantissa divider, one quotient digit per cycle.
// Define SRT_DIV_EARLY_TERM_EN to finish as soon as the partial remainder becomes zero.
module srt_radix2_iter
    import srt_div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_dividend,
    input  logic [MANT_W-1:0] in_divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER-1:0]   quotient,
    output logic [REM_W-1:0]  current_remainder,
    output logic [REM_W-1:0]  current_divisor,
    output logic              div_err
);

    srt_state_t        r_state;
    logic [MANT_W-1:0] r_d;
    logic [REM_W-1:0]  r_rem;
    logic [ITER-1:0]   r_q;
    logic [ITER-2:0]   r_qm;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic [REM_W:0]    w_r0Full;
    logic [REM_W:0]    w_twoR;
    logic [REM_W-1:0]  w_dAligned;
    logic [REM_W-1:0]  w_rNext;
    logic [ITER-1:0]   w_qNext;
    logic [ITER-2:0]   w_qmNext;
    logic [ITER-1:0]   w_qFinal;
    srt_digit_t        w_digit;
    logic              w_lastDigit;
    logic              w_stop;
    logic              w_unused;

    // Halving x keeps the first partial remainder strictly below d.
    assign w_r0Full   = {3'b000, in_dividend} >> 1;
    assign w_unused   = w_r0Full[REM_W];

    assign w_twoR     = {r_rem, 1'b0};
    assign w_dAligned = {2'b00, r_d};

    srt_qds u_qds (
        .i_estimate (w_twoR[REM_W:REM_W-3]),
        .o_digit    (w_digit)
    );

    // |r'| <= d always holds, so the low REM_W bits of 2r -/+ d are exact.
    always_comb begin
        w_rNext = w_twoR[REM_W-1:0];
        case (w_digit)
            Q_POS:   w_rNext = w_twoR[REM_W-1:0] - w_dAligned;
            Q_NEG:   w_rNext = w_twoR[REM_W-1:0] + w_dAligned;
            default: w_rNext = w_twoR[REM_W-1:0];
        endcase
    end

    // On-the-fly conversion keeps Q and QM = Q - 1ulp so a -1 digit needs no borrow.
    always_comb begin
        w_qNext  = {r_q[ITER-2:0], 1'b0};
        w_qmNext = {r_qm[ITER-3:0], 1'b1};
        case (w_digit)
            Q_POS: begin
                w_qNext  = {r_q[ITER-2:0], 1'b1};
                w_qmNext = {r_q[ITER-3:0], 1'b0};
            end
            Q_NEG: begin
                w_qNext  = {r_qm, 1'b1};
                w_qmNext = {r_qm[ITER-3:0], 1'b0};
            end
            default: begin
                w_qNext  = {r_q[ITER-2:0], 1'b0};
                w_qmNext = {r_qm[ITER-3:0], 1'b1};
            end
        endcase
    end

    assign w_lastDigit = (r_cnt == CNT_W'(ITER - 1));

`ifdef SRT_DIV_EARLY_TERM_EN
    logic             w_rZero;
    logic [CNT_W-1:0] w_shift;

    // Once r' is zero every later digit is zero, so the missing digits are zero fill.
    assign w_rZero  = (w_rNext == '0);
    assign w_shift  = CNT_W'(ITER - 1) - r_cnt;
    assign w_stop   = w_lastDigit || w_rZero;
    assign w_qFinal = w_rZero ? (w_qNext << w_shift) : w_qNext;
`else
    assign w_stop   = w_lastDigit;
    assign w_qFinal = w_qNext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_d     <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_qm    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_d   <= in_divisor;
                        r_qm  <= '0;
                        r_cnt <= '0;
                        if (!in_divisor[MANT_W-1]) begin
                            r_err   <= 1'b1;
                            r_q     <= '1;
                            r_rem   <= '0;
                            r_state <= DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_q     <= '0;
                            r_rem   <= w_r0Full[REM_W-1:0];
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rNext;
                    r_qm  <= w_qmNext;
                    r_q   <= w_qFinal;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_stop) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready          = (r_state == IDLE);
    assign out_valid         = (r_state == DONE);
    assign quotient          = r_q;
    assign current_remainder = r_rem;
    assign current_divisor   = w_dAligned;
    assign div_err           = r_err;

endmodule

// File: tb/tb_srt_radix2_iter.sv
// Self-checking bench for srt_radix2_iter: directed operations scored through an expected-result queue.
`timescale 1ns/1ps
module tb_srt_radix2_iter;
    import srt_div_pkg::*;

    typedef struct {
        logic [MANT_W-1:0] x;
        logic [MANT_W-1:0] d;
        logic [ITER-1:0]   q;
        logic [REM_W-1:0]  r;
        logic              err;
    } expect_t;

`ifdef SRT_DIV_EARLY_TERM_EN
    localparam int NORMAL_LAT = 0;
`else
    localparam int NORMAL_LAT = ITER + 1;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_dividend;
    logic [MANT_W-1:0] in_divisor;
    logic              out_valid;
    logic              out_ready;
    logic [ITER-1:0]   quotient;
    logic [REM_W-1:0]  current_remainder;
    logic [REM_W-1:0]  current_divisor;
    logic              div_err;

    expect_t scoreboard[$];
    int      testCount = 0;
    int      failCount = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    srt_radix2_iter dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_dividend       (in_dividend),
        .in_divisor        (in_divisor),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .quotient          (quotient),
        .current_remainder (current_remainder),
        .current_divisor   (current_divisor),
        .div_err           (div_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: integer SRT recurrence with digit chosen from floor(2r).
    function automatic expect_t modelDivide(input logic [MANT_W-1:0] x, input logic [MANT_W-1:0] d);
        expect_t e;
        longint  r;
        longint  t;
        longint  q;
        longint  one;
        e.x = x;
        e.d = d;
        if (!d[MANT_W-1]) begin
            e.err = 1'b1;
            e.q   = '1;
            e.r   = '0;
            return e;
        end
        one = longint'(1) << (MANT_W - 1);
        r = longint'(x) / 2;
        q = 0;
        for (int i = 0; i < ITER; i++) begin
            t = 2 * r;
            if (t >= one) begin
                q = 2 * q + 1;
                r = t - longint'(d);
            end else if (t < -one) begin
                q = 2 * q - 1;
                r = t + longint'(d);
            end else begin
                q = 2 * q;
                r = t;
            end
        end
        e.err = 1'b0;
        e.q   = q[ITER-1:0];
        e.r   = r[REM_W-1:0];
        return e;
    endfunction

    task automatic applyStimulus(input logic [MANT_W-1:0] x, input logic [MANT_W-1:0] d);
        int waitCycles = 0;
        @(negedge clk);
        while (!in_ready && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("ready_before_issue", in_ready, 1);
        in_valid    = 1'b1;
        in_dividend = x;
        in_divisor  = d;
        scoreboard.push_back(modelDivide(x, d));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collectResult(input string tag, input int expLatency, output expect_t e, output int edges);
        longint lhs;
        longint rhs;
        longint rVal;
        longint rAbs;
        edges = 1;
        while (!out_valid && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        checkOutput({tag, "_valid"}, out_valid, 1);
        if (expLatency != 0) checkOutput({tag, "_latency"}, edges, expLatency);
        checkOutput({tag, "_pending"}, scoreboard.size(), 1);
        if (scoreboard.size() == 0) begin
            e = modelDivide('0, '0);
            return;
        end
        e = scoreboard.pop_front();
        checkOutput({tag, "_quotient"}, quotient, e.q);
        checkOutput({tag, "_remainder"}, current_remainder, e.r);
        checkOutput({tag, "_div_err"}, div_err, e.err);
        checkOutput({tag, "_divisor"}, current_divisor, {2'b00, e.d});
        if (!e.err) begin
            rVal = longint'($signed(current_remainder));
            lhs  = longint'(e.x) * (longint'(1) << (ITER - 1));
            rhs  = longint'(quotient) * longint'(current_divisor) + rVal;
            checkOutput({tag, "_identity"}, rhs, lhs);
            rAbs = (rVal < 0) ? -rVal : rVal;
            checkOutput({tag, "_rem_bound"}, rAbs <= longint'(e.d), 1);
        end
    endtask

    task automatic releaseResult(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_back_to_idle"}, {in_ready, out_valid}, 2'b10);
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        expect_t           e;
        int                edges;
        logic [MANT_W-1:0] rx;
        logic [MANT_W-1:0] rd;

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_quotient", quotient, 0);
        checkOutput("reset_remainder", current_remainder, 0);
        checkOutput("reset_divisor", current_divisor, 0);
        checkOutput("reset_div_err", div_err, 0);
        rst = 1'b0;

        applyStimulus(24'h800000, 24'h800000);
        collectResult("t1", 0, e, edges);
        checkOutput("t1_quotient_const", quotient, 26'h2000000);
        checkOutput("t1_remainder_zero", current_remainder, 0);
`ifdef SRT_DIV_EARLY_TERM_EN
        checkOutput("t1_early_latency", edges < ITER + 1, 1);
`else
        checkOutput("t1_latency_exact", edges, ITER + 1);
`endif
        releaseResult("t1");

        applyStimulus(24'hC00000, 24'h800000);
        collectResult("t2", NORMAL_LAT, e, edges);
        checkOutput("t2_quotient_const", quotient, 26'h3000000);
        releaseResult("t2");

        applyStimulus(24'h800000, 24'hC00000);
        collectResult("t3", NORMAL_LAT, e, edges);
        checkOutput("t3_quotient_range", (quotient == 26'h1555555) || (quotient == 26'h1555556), 1);
        releaseResult("t3");

        applyStimulus(24'hA00000, 24'h400000);
        collectResult("t4", 1, e, edges);
        checkOutput("t4_quotient_ones", quotient, 26'h3FFFFFF);
        releaseResult("t4");

        applyStimulus(24'h900000, 24'hA00000);
        collectResult("t5", NORMAL_LAT, e, edges);
        for (int i = 0; i < 5; i++) begin
            in_valid    = 1'b1;
            in_dividend = 24'hFFFFFE;
            in_divisor  = 24'h800000;
            @(negedge clk);
            checkOutput("t5_hold_valid", out_valid, 1);
            checkOutput("t5_hold_in_ready", in_ready, 0);
            checkOutput("t5_hold_quotient", quotient, e.q);
            checkOutput("t5_hold_remainder", current_remainder, e.r);
            checkOutput("t5_hold_divisor", current_divisor, {2'b00, e.d});
        end
        in_valid = 1'b0;
        releaseResult("t5");

        applyStimulus(24'hD00000, 24'h900000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_abort_in_ready", in_ready, 1);
        checkOutput("t6_abort_out_valid", out_valid, 0);
        checkOutput("t6_abort_quotient", quotient, 0);
        checkOutput("t6_abort_remainder", current_remainder, 0);
        void'(scoreboard.pop_back());
        @(negedge clk);
        checkOutput("t6_no_late_output", out_valid, 0);
        applyStimulus(24'hD00000, 24'h900000);
        collectResult("t6_retry", NORMAL_LAT, e, edges);
        releaseResult("t6_retry");

        for (int k = 0; k < 6; k++) begin
            rx = {1'b1, 22'($urandom), 1'b0};
            rd = {1'b1, 23'($urandom)};
            applyStimulus(rx, rd);
            collectResult("rand", NORMAL_LAT, e, edges);
            releaseResult("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
